// File: rtl/mem_stage_hs.sv
// Handshaked MEM pipeline stage: holds one instruction, waits for the data-SRAM read
// response, extracts/extends the load result by byte lane and forwards the write to WB.
module mem_stage_hs #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned RF_AW  = 5,
    parameter int unsigned SIDE_W = 66
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_res,
    input  logic [2:0]        in_ld_op,
    input  logic              in_rf_we,
    input  logic [RF_AW-1:0]  in_rf_waddr,
    input  logic [SIDE_W-1:0] in_side,
    input  logic              dresp_valid,
    input  logic [DATA_W-1:0] dresp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic              out_rf_we,
    output logic [RF_AW-1:0]  out_rf_waddr,
    output logic [DATA_W-1:0] out_rf_wdata,
    output logic [SIDE_W-1:0] out_side,
    output logic              out_adel,
    output logic              load_pending
);

    localparam int unsigned LANE_W = $clog2(DATA_W / 8);
    localparam logic [DATA_W-1:0] M8  = ~({DATA_W{1'b1}} << 8);
    localparam logic [DATA_W-1:0] M16 = ~({DATA_W{1'b1}} << 16);
    localparam logic [DATA_W-1:0] M32 = ~({DATA_W{1'b1}} << 32);

    typedef enum logic [1:0] {StIdle, StWait, StFull} state_e;

    state_e state_q, state_d, accept_tgt;
    logic   drop_q, drop_d;

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [2:0]        op_q, op_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              we_q, we_d;
    logic [RF_AW-1:0]  waddr_q, waddr_d;
    logic [SIDE_W-1:0] side_q, side_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              adel_q, adel_d;

    logic              accept;
    logic [2:0]        in_op_eff;
    logic [2:0]        in_lane3;
    logic              in_misal;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] ld_data;

    assign accept = in_valid && in_ready;

    // A 32-bit datapath has no doubleword loads: LWU/LD collapse onto LW.
    always_comb begin : decode_in
        in_op_eff = in_ld_op;
        if (DATA_W == 32 && in_ld_op >= 3'd6) in_op_eff = 3'd5;
        in_lane3 = 3'(in_res[LANE_W-1:0]);
        case (in_op_eff)
            3'd3, 3'd4: in_misal = in_lane3[0];
            3'd5, 3'd6: in_misal = |in_lane3[1:0];
            3'd7:       in_misal = |in_lane3;
            default:    in_misal = 1'b0;
        endcase
        accept_tgt = (in_op_eff == 3'd0 || in_misal) ? StFull : StWait;
    end

    always_comb begin : extract
        shifted = dresp_data >> {lane_q, 3'b000};
        case (op_q)
            3'd1:    ld_data = (shifted & M8) | (~M8 & {DATA_W{shifted[7]}});
            3'd2:    ld_data = shifted & M8;
            3'd3:    ld_data = (shifted & M16) | (~M16 & {DATA_W{shifted[15]}});
            3'd4:    ld_data = shifted & M16;
            3'd5:    ld_data = (shifted & M32) | (~M32 & {DATA_W{shifted[31]}});
            3'd6:    ld_data = shifted & M32;
            default: ld_data = shifted;
        endcase
    end

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state_q <= StIdle;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    // A flushed load still has its response in flight; drop swallows it.
    always_comb begin : next_state
        state_d = state_q;
        drop_d  = drop_q;
        if (flush) begin
            state_d = StIdle;
            if (state_q == StWait && !dresp_valid) drop_d = 1'b1;
        end else begin
            case (state_q)
                StIdle:  if (accept) state_d = accept_tgt;
                StWait:  if (dresp_valid) state_d = StFull;
                StFull:  if (out_ready) state_d = accept ? accept_tgt : StIdle;
                default: state_d = StIdle;
            endcase
        end
        if (drop_q && dresp_valid) drop_d = 1'b0;
    end

    always_comb begin : outputs
        out_valid    = (state_q == StFull);
        load_pending = (state_q == StWait);
        in_ready     = !rst && !flush && !drop_q &&
                       (state_q == StIdle || (state_q == StFull && out_ready));
    end

    always_comb begin : datapath_next
        pc_d    = pc_q;
        op_d    = op_q;
        lane_d  = lane_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        side_d  = side_q;
        wdata_d = wdata_q;
        adel_d  = adel_q;
        if (accept) begin
            pc_d    = in_pc;
            op_d    = in_op_eff;
            lane_d  = in_res[LANE_W-1:0];
            waddr_d = in_rf_waddr;
            side_d  = in_side;
            adel_d  = in_misal;
            we_d    = in_rf_we && !in_misal;
            wdata_d = (in_op_eff == 3'd0) ? in_res : '0;
        end else if (state_q == StWait && dresp_valid && !flush) begin
            wdata_d = ld_data;
        end
    end

    always_ff @(posedge clk) begin : datapath_reg
        if (rst) begin
            pc_q    <= '0;
            op_q    <= '0;
            lane_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            side_q  <= '0;
            wdata_q <= '0;
            adel_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            op_q    <= op_d;
            lane_q  <= lane_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            side_q  <= side_d;
            wdata_q <= wdata_d;
            adel_q  <= adel_d;
        end
    end

    assign out_pc       = pc_q;
    assign out_rf_we    = we_q;
    assign out_rf_waddr = waddr_q;
    assign out_rf_wdata = wdata_q;
    assign out_side     = side_q;
    assign out_adel     = adel_q;

    // A response is only legal while a load waits or a flushed one is being dropped.
    a_dresp_legal: assert property (@(posedge clk) disable iff (rst)
        dresp_valid |-> (state_q == StWait || drop_q));

endmodule

// File: tb/tb_mem_stage_hs.sv
// Bench for mem_stage_hs: directed cases on 32- and 64-bit instances, then random
// traffic checked against a transaction-level reference model.
module tb_mem_stage_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, in_rf_we, dresp_valid, out_ready, sel64;
    logic [31:0] in_pc;
    logic [63:0] in_res, dresp_data;
    logic [2:0]  in_ld_op;
    logic [4:0]  in_rf_waddr;
    logic [65:0] in_side;

    logic        iv32, dv32, ir32, ov32, we32, ad32, lp32;
    logic        iv64, dv64, ir64, ov64, we64, ad64, lp64;
    logic [31:0] pc32, pc64, wd32;
    logic [63:0] wd64;
    logic [4:0]  wa32, wa64;
    logic [65:0] sd32, sd64;

    logic        o_ir, o_ov, o_we, o_ad, o_lp;
    logic [31:0] o_pc;
    logic [63:0] o_wd;
    logic [4:0]  o_wa;
    logic [65:0] o_sd;

    int n_chk = 0;
    int n_fail = 0;

    assign iv32 = in_valid & ~sel64;
    assign dv32 = dresp_valid & ~sel64;
    assign iv64 = in_valid & sel64;
    assign dv64 = dresp_valid & sel64;

    mem_stage_hs #(.DATA_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv32), .in_ready(ir32),
        .in_pc(in_pc), .in_res(in_res[31:0]), .in_ld_op(in_ld_op), .in_rf_we(in_rf_we),
        .in_rf_waddr(in_rf_waddr), .in_side(in_side), .dresp_valid(dv32),
        .dresp_data(dresp_data[31:0]), .out_valid(ov32), .out_ready(out_ready),
        .out_pc(pc32), .out_rf_we(we32), .out_rf_waddr(wa32), .out_rf_wdata(wd32),
        .out_side(sd32), .out_adel(ad32), .load_pending(lp32)
    );

    mem_stage_hs #(.DATA_W(64)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv64), .in_ready(ir64),
        .in_pc(in_pc), .in_res(in_res), .in_ld_op(in_ld_op), .in_rf_we(in_rf_we),
        .in_rf_waddr(in_rf_waddr), .in_side(in_side), .dresp_valid(dv64),
        .dresp_data(dresp_data), .out_valid(ov64), .out_ready(out_ready),
        .out_pc(pc64), .out_rf_we(we64), .out_rf_waddr(wa64), .out_rf_wdata(wd64),
        .out_side(sd64), .out_adel(ad64), .load_pending(lp64)
    );

    always_comb begin
        o_ir = sel64 ? ir64 : ir32;
        o_ov = sel64 ? ov64 : ov32;
        o_we = sel64 ? we64 : we32;
        o_ad = sel64 ? ad64 : ad32;
        o_lp = sel64 ? lp64 : lp32;
        o_pc = sel64 ? pc64 : pc32;
        o_wd = sel64 ? wd64 : {32'd0, wd32};
        o_wa = sel64 ? wa64 : wa32;
        o_sd = sel64 ? sd64 : sd32;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [63:0] res, input logic we,
                         input logic [4:0] wa, input logic [31:0] pc);
        in_valid    = 1'b1;
        in_ld_op    = op;
        in_res      = res;
        in_rf_we    = we;
        in_rf_waddr = wa;
        in_pc       = pc;
        in_side     = {2'b10, pc, ~pc};
    endtask

    // Load whose response arrives two cycles after accept; result visible the cycle after.
    task automatic do_load(input string tag, input logic [2:0] op, input logic [63:0] addr,
                           input logic [63:0] data, input logic [63:0] exp);
        cyc();
        drive(op, addr, 1'b1, 5'd5, 32'h200);
        cyc();
        in_valid = 1'b0;
        settle();
        chk({tag, ".pending"}, o_lp, 1'b1);
        cyc();
        dresp_valid = 1'b1;
        dresp_data  = data;
        settle();
        chk({tag, ".no_valid"}, o_ov, 1'b0);
        cyc();
        dresp_valid = 1'b0;
        settle();
        chk({tag, ".valid"}, o_ov, 1'b1);
        chk({tag, ".wdata"}, o_wd, exp);
        chk({tag, ".adel"}, o_ad, 1'b0);
    endtask

    // Reference: result of an instruction from its op, address/result and memory word.
    function automatic logic [63:0] ref_result(input bit is64, input logic [2:0] op,
                                               input logic [63:0] res_in,
                                               input logic [63:0] data_in, output bit adel);
        int          size, lane;
        bit          sgn;
        logic [63:0] res, data, v, m;
        res  = is64 ? res_in : (res_in & 64'hFFFF_FFFF);
        data = is64 ? data_in : (data_in & 64'hFFFF_FFFF);
        adel = 1'b0;
        if (op == 3'd0) return res;
        case (op)
            3'd1:    begin size = 1; sgn = 1'b1; end
            3'd2:    begin size = 1; sgn = 1'b0; end
            3'd3:    begin size = 2; sgn = 1'b1; end
            3'd4:    begin size = 2; sgn = 1'b0; end
            3'd5:    begin size = 4; sgn = 1'b1; end
            3'd6:    begin size = 4; sgn = 1'b0; end
            default: begin size = 8; sgn = 1'b0; end
        endcase
        if (!is64 && op >= 3'd6) begin size = 4; sgn = 1'b1; end
        lane = int'(res % (is64 ? 64'd8 : 64'd4));
        if (lane % size != 0) begin
            adel = 1'b1;
            return 64'd0;
        end
        v = data >> (8 * lane);
        if (size < 8) begin
            m = (64'd1 << (8 * size)) - 64'd1;
            v = v & m;
            if (sgn && v[8*size-1]) v = v | ~m;
        end
        if (!is64) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    task automatic rand_phase(input bit is64, input int ncyc);
        bit          m_have, m_wait, exp_ov, exp_ir, exp_lp, adel;
        int          m_cnt;
        logic [63:0] m_data, e_wd;
        logic [31:0] e_pc;
        logic [4:0]  e_wa;
        logic [65:0] e_sd;
        logic        e_we, e_ad;
        m_have = 1'b0;
        m_wait = 1'b0;
        m_cnt  = 0;
        m_data = '0;
        for (int i = 0; i < ncyc + 10; i++) begin
            cyc();
            out_ready   = (i >= ncyc) || ($urandom % 4 != 0);
            dresp_valid = 1'b0;
            if (m_wait) begin
                if (m_cnt == 0) begin
                    dresp_valid = 1'b1;
                    dresp_data  = m_data;
                end else begin
                    m_cnt--;
                end
            end
            in_valid    = (i < ncyc) && ($urandom % 3 != 0);
            in_ld_op    = 3'($urandom);
            in_res      = {$urandom, $urandom};
            in_rf_we    = 1'($urandom);
            in_rf_waddr = 5'($urandom);
            in_pc       = $urandom;
            in_side     = {2'($urandom), $urandom, $urandom};
            settle();
            exp_ov = m_have && !m_wait;
            exp_lp = m_have && m_wait;
            exp_ir = !m_have || (exp_ov && out_ready);
            chk("rnd.out_valid", o_ov, exp_ov);
            chk("rnd.in_ready", o_ir, exp_ir);
            chk("rnd.load_pending", o_lp, exp_lp);
            if (exp_ov && out_ready) begin
                chk("rnd.pc", o_pc, e_pc);
                chk("rnd.we", o_we, e_we);
                chk("rnd.waddr", o_wa, e_wa);
                chk("rnd.wdata", o_wd, e_wd);
                chk("rnd.side", o_sd, e_sd);
                chk("rnd.adel", o_ad, e_ad);
                m_have = 1'b0;
            end
            if (dresp_valid) m_wait = 1'b0;
            if (in_valid && exp_ir) begin
                m_data = {$urandom, $urandom};
                e_wd   = ref_result(is64, in_ld_op, in_res, m_data, adel);
                e_pc   = in_pc;
                e_wa   = in_rf_waddr;
                e_sd   = in_side;
                e_ad   = adel;
                e_we   = in_rf_we && !adel;
                m_have = 1'b1;
                m_wait = (in_ld_op != 3'd0) && !adel;
                m_cnt  = $urandom_range(0, 3);
            end
        end
        in_valid    = 1'b0;
        dresp_valid = 1'b0;
        out_ready   = 1'b1;
    endtask

    initial begin
        logic [31:0] hold_wd;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rf_we = 1'b0; dresp_valid = 1'b0;
        out_ready = 1'b1; sel64 = 1'b0; in_pc = '0; in_res = '0; dresp_data = '0;
        in_ld_op = '0; in_rf_waddr = '0; in_side = '0;
        cyc();
        cyc();
        settle();
        chk("rst.in_ready", o_ir, 1'b0);
        chk("rst.out_valid", o_ov, 1'b0);
        chk("rst.load_pending", o_lp, 1'b0);
        chk("rst.wdata", o_wd, 64'd0);
        chk("rst.pc", o_pc, 32'd0);
        chk("rst.adel", o_ad, 1'b0);
        rst = 1'b0;

        // Non-load, latency 1
        drive(3'd0, 64'h1234_5678, 1'b1, 5'd3, 32'h100);
        settle();
        chk("nl.in_ready", o_ir, 1'b1);
        cyc();
        in_valid = 1'b0;
        settle();
        chk("nl.out_valid", o_ov, 1'b1);
        chk("nl.wdata", o_wd, 64'h1234_5678);
        chk("nl.adel", o_ad, 1'b0);
        chk("nl.we", o_we, 1'b1);
        chk("nl.waddr", o_wa, 5'd3);
        chk("nl.pc", o_pc, 32'h100);

        do_load("lb", 3'd1, 64'h1001, 64'h0000_80FF, 64'hFFFF_FF80);
        do_load("lbu", 3'd2, 64'h1001, 64'h0000_80FF, 64'h0000_0080);
        do_load("lh", 3'd3, 64'h1002, 64'h8001_0000, 64'hFFFF_8001);

        // Misaligned LH: straight to FULL with adel
        cyc();
        drive(3'd3, 64'h1003, 1'b1, 5'd7, 32'h300);
        cyc();
        in_valid = 1'b0;
        settle();
        chk("mis.out_valid", o_ov, 1'b1);
        chk("mis.adel", o_ad, 1'b1);
        chk("mis.we", o_we, 1'b0);
        chk("mis.wdata", o_wd, 64'd0);
        chk("mis.pending", o_lp, 1'b0);

        // Backpressure then back-to-back
        cyc();
        drive(3'd0, 64'hAAAA_0001, 1'b1, 5'd1, 32'h400);
        cyc();
        drive(3'd0, 64'hBBBB_0002, 1'b1, 5'd2, 32'h404);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("bp.in_ready", o_ir, 1'b0);
            chk("bp.out_valid", o_ov, 1'b1);
            hold_wd = o_wd[31:0];
            chk("bp.wdata", o_wd, 64'hAAAA_0001);
            cyc();
        end
        out_ready = 1'b1;
        settle();
        chk("bp.release_ready", o_ir, 1'b1);
        cyc();
        in_valid = 1'b0;
        settle();
        chk("b2b.out_valid", o_ov, 1'b1);
        chk("b2b.wdata", o_wd, 64'hBBBB_0002);
        chk("b2b.pc", o_pc, 32'h404);

        // Flush in WAIT, response three cycles later
        cyc();
        drive(3'd5, 64'h2000, 1'b1, 5'd9, 32'h500);
        cyc();
        in_valid = 1'b0;
        flush    = 1'b1;
        settle();
        chk("fl.ready_flush", o_ir, 1'b0);
        cyc();
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("fl.drop_ready", o_ir, 1'b0);
            chk("fl.out_valid", o_ov, 1'b0);
            chk("fl.pending", o_lp, 1'b0);
            cyc();
        end
        dresp_valid = 1'b1;
        dresp_data  = 64'hDEAD_BEEF;
        settle();
        chk("fl.ready_at_resp", o_ir, 1'b0);
        cyc();
        dresp_valid = 1'b0;
        settle();
        chk("fl.ready_after", o_ir, 1'b1);
        chk("fl.out_valid_after", o_ov, 1'b0);

        // Flush coincident with response
        drive(3'd5, 64'h2004, 1'b1, 5'd9, 32'h504);
        cyc();
        in_valid = 1'b0;
        cyc();
        flush       = 1'b1;
        dresp_valid = 1'b1;
        cyc();
        flush       = 1'b0;
        dresp_valid = 1'b0;
        settle();
        chk("flc.in_ready", o_ir, 1'b1);
        chk("flc.out_valid", o_ov, 1'b0);
        chk("flc.pending", o_lp, 1'b0);

        // Reset while waiting
        drive(3'd5, 64'h2008, 1'b1, 5'd9, 32'h508);
        cyc();
        in_valid = 1'b0;
        settle();
        chk("rw.pending", o_lp, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        settle();
        chk("rw.pending_after", o_lp, 1'b0);
        chk("rw.out_valid", o_ov, 1'b0);
        chk("rw.in_ready", o_ir, 1'b1);

        sel64 = 1'b1;
        do_load("ld64", 3'd7, 64'h8, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);
        do_load("lw64", 3'd5, 64'h4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000);
        do_load("lwu64", 3'd6, 64'h4, 64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000);
        cyc();

        rand_phase(1'b1, 400);
        sel64 = 1'b0;
        cyc();
        rand_phase(1'b0, 400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
Parametrised, handshaked memory-access pipeline stage sitting between EX and WB.
- Holds one instruction and waits a variable number of cycles for the data-SRAM read response.
- Extracts and sign/zero-extends the load result by byte lane, flags misaligned loads, and forwards the register write to WB.
- Supports 32- or 64-bit datapaths and an opaque sideband field (e.g. hi/lo write bus) carried alongside each instruction.

Parameters:
DATA_W, 32, datapath/SRAM word width; legal values 32 or 64.
PC_W, 32, PC width carried for debug/trace.
RF_AW, 5, register-file address width.
SIDE_W, 66, width of opaque sideband passed EX->WB unchanged.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard held instruction (exception/redirect)
in_valid  in  1  EX presents an instruction
in_ready  out  1  stage accepts this cycle
in_pc  in  PC_W  instruction PC
in_res  in  DATA_W  EX result; the load address when in_ld_op!=0
in_ld_op  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWU, 7 LD
in_rf_we  in  1  register write enable
in_rf_waddr  in  RF_AW  destination register
in_side  in  SIDE_W  sideband
dresp_valid  in  1  SRAM read data valid (single-cycle pulse)
dresp_data  in  DATA_W  SRAM read word
out_valid  out  1  WB-bound result valid
out_ready  in  1  WB accepts
out_pc  out  PC_W  registered PC
out_rf_we  out  1  registered write enable; 0 when out_adel=1
out_rf_waddr  out  RF_AW  registered destination
out_rf_wdata  out  DATA_W  load result or in_res
out_side  out  SIDE_W  registered sideband
out_adel  out  1  misaligned-load flag
load_pending  out  1  1 while in WAIT; drives the hazard unit's load-use stall

Behaviour:
Reset and clocking:
- Reset is rst, synchronous, active-high; clock is clk.
- On reset: state=IDLE, drop=0, out_valid=0, and all registered outputs = 0. in_ready=0 while rst is high.

States (single-entry holding register):
- IDLE: empty.
- WAIT: load accepted, awaiting dresp_valid.
- FULL: result valid.

Handshake and transitions:
- in_ready = !flush && !drop && (IDLE || (FULL && out_ready)).
- Accept = in_valid && in_ready; on accept, capture pc, res, op, we, waddr and side.
- Accepted non-load (op=0): -> FULL next cycle; wdata = in_res. Latency 1.
- Accepted aligned load: -> WAIT.
- Accepted misaligned load: -> FULL directly; out_adel=1, out_rf_we=0. No response is expected because EX suppresses the request.
- In WAIT with dresp_valid: extract the result and register it into out_rf_wdata; -> FULL next cycle. Minimum load latency is 2 cycles (response no earlier than the cycle after accept).
- FULL && out_ready && no new accept: -> IDLE.
- FULL && out_ready && accept: load the new entry back-to-back with no bubble.
- out_valid = (state==FULL). out_* hold stable while out_valid && !out_ready.

Extraction (lane = res[log2(DATA_W/8)-1:0]):
- LB/LBU: byte at lane*8, sign-/zero-extended to DATA_W.
- LH/LHU: halfword at lane*8; requires lane[0]=0.
- LW/LWU: word at lane*8; requires lane[1:0]=0. LW sign-extends; LWU zero-extends.
- LD: full word; requires lane[2:0]=0.
- DATA_W=32: codes 6 and 7 behave as 5 (LW); lane is 2 bits.
- Any misalignment sets adel and forces wdata=0.

Flush:
- Highest priority: next state IDLE, out_valid=0, and no accept that cycle.
- Flush in WAIT without dresp_valid in the same cycle sets drop=1.
- While drop=1, in_ready=0. The next dresp_valid is discarded and clears drop.
- Flush in WAIT coinciding with dresp_valid: response discarded, drop stays 0.
- dresp_valid in IDLE/FULL with drop=0 is ignored. This is a protocol error; assertion only.

load_pending: 1 exactly when state==WAIT.

Test Plan:
- Non-load (32-bit): in_res=0x12345678, we=1, waddr=3, out_ready=1 -> out_valid one cycle later, wdata=0x12345678, adel=0.
- LB sign-extend (32-bit): res=0x1001, dresp 2 cycles later with data=0x0000_80FF -> wdata=0xFFFF_FF80 one cycle after dresp. Same case with LBU -> 0x0000_0080.
- Misaligned: LH at addr 0x1003 -> FULL next cycle with adel=1, rf_we=0, wdata=0, no wait. LD at 0x8 with DATA_W=64, data=0x8000_0000_0000_0001 -> wdata equal to data.
- Backpressure/back-to-back: two non-loads, out_ready=0 for 3 cycles -> outputs stable, in_ready=0. Then out_ready=1 -> second result in the very next cycle.
- Flush in WAIT: flush 1 cycle after LW accept, dresp arrives 3 cycles later -> in_ready=0 until that dresp, no out_valid, then in_ready=1. Flush coincident with dresp -> in_ready=1 the next cycle.
- Reset mid-WAIT: rst asserted -> state IDLE, drop=0, out_valid=0, load_pending=0 the following cycle.
